ccg_response_analyzer: RTL
==========================

CCG_RESPONSE_ANALYZER -- requirements
Module: ccg_response_analyzer

Interface
REQ-001 Parameter N_IN, default 3: width of the generated circuit's input vector (x0..x2).
REQ-002 Parameter N_OUT, default 10: width of the generated circuit's output vector (f1..f10).
REQ-003 Parameter SIG_W, default 16: MISR signature width; N_OUT SHALL be <= SIG_W.
REQ-004 Parameter SETTLE, default 1, range 1..15: cycles each pattern is held before capture.
REQ-005 Parameter SEED, default 16'h0000: MISR initial value.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 start  input  1  begin one exhaustive test run; sampled only in IDLE or DONE.
REQ-009 golden  input  SIG_W  expected signature; captured on the edge that accepts start.
REQ-010 x  output  N_IN  stimulus to the circuit under test (bit 0 = x0).
REQ-011 f  input  N_OUT  response from the circuit under test (bit 0 = f1).
REQ-012 busy  output  1  high in APPLY and CAPTURE.
REQ-013 done  output  1  high in DONE; held until next accepted start or reset.
REQ-014 pass  output  1  signature == captured golden; valid while done is high, 0 otherwise.
REQ-015 signature  output  SIG_W  current MISR value.

Function
REQ-016 FSM states SHALL be IDLE, APPLY, CAPTURE, DONE.
REQ-017 IDLE/DONE + start=1 -> APPLY; x <= 0, pattern count <= 0, MISR <= SEED, settle count <= 0, golden latched, done/pass <= 0.
REQ-018 start while busy SHALL be ignored with no effect.
REQ-019 APPLY SHALL hold x for exactly SETTLE cycles, then go to CAPTURE.
REQ-020 CAPTURE lasts one cycle, x unchanged; f sampled on the edge leaving CAPTURE.
REQ-021 MISR update: next = {sig[SIG_W-2:0],1'b0} XOR (sig[SIG_W-1] ? 16'h1021 : 0) XOR zero-extended f.
REQ-022 Leaving CAPTURE with pattern count < 2^N_IN-1 -> APPLY, x and count +1; else -> DONE.
REQ-023 Exactly 2^N_IN patterns (0..2^N_IN-1, ascending) SHALL be applied per run; x SHALL NOT wrap within a run.
REQ-024 done SHALL rise 2^N_IN*(SETTLE+1)+1 edges after the edge accepting start (17 for defaults).
REQ-025 pass SHALL be registered on the edge entering DONE, comparing the final MISR with latched golden.
REQ-026 In DONE, x and signature SHALL hold their final values; start re-arms per REQ-017.
REQ-027 golden changes after acceptance SHALL NOT affect pass.

Reset
REQ-028 rst=1 on an edge SHALL force IDLE, x=0, MISR=SEED, counters=0, busy=0, done=0, pass=0, from any state including mid-run.
REQ-029 rst SHALL dominate start on the same edge.

Structure
REQ-030 State enum, polynomial constant 16'h1021 and default SIG_W SHALL live in package ccg_test_pkg.
REQ-031 MISR SHALL be a separate sub-module ccg_misr (clk, rst, load, seed, en, din, sig); FSM and counters in the top.

Verification
REQ-032 f tied to 0, golden=0, start one cycle -> done on 17th edge, signature=16'h0000, pass=1.
REQ-033 f=10'h001 only when x=0, else 0 -> final signature=16'h0080; golden=16'h0080 gives pass=1, golden=16'h0081 gives pass=0.
REQ-034 Monitor x during run -> values 0,1,...,7, each held SETTLE+1 cycles; with SETTLE=3 done at edge 33.
REQ-035 rst asserted at edge 9 of a run -> next cycle IDLE, busy=0, x=0, signature=SEED; a new start completes normally.
REQ-036 start pulsed at edges 5 and 10 of a run -> ignored, done still at edge 17; start in DONE restarts with done=0 next cycle.
REQ-037 Connect generated CCGRCG-style netlist as CUT, golden from reference model signature -> pass=1; invert one f bit in model -> pass=0.

Source files
------------

// File: rtl/ccg_test_pkg.sv
// rtl/ccg_test_pkg.sv - shared types and constants for the CCG response analyzer
package ccg_test_pkg;

  localparam int          CCG_SIG_W = 16;
  localparam logic [15:0] CCG_POLY  = 16'h1021;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_CAPTURE,
    ST_DONE
  } ccg_state_t;

endpackage

// File: rtl/ccg_response_analyzer_if.sv
// rtl/ccg_response_analyzer_if.sv - control and CUT-facing signal bundle of the analyzer
interface ccg_response_analyzer_if
  import ccg_test_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int N_OUT = 10,
  parameter int SIG_W = CCG_SIG_W
);

  logic             start;
  logic [SIG_W-1:0] golden;
  logic [N_IN-1:0]  x;
  logic [N_OUT-1:0] f;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;

  // analyzer side
  modport slave (
    input  start, golden, f,
    output x, busy, done, pass, signature
  );

  // controller / CUT side
  modport master (
    output start, golden, f,
    input  x, busy, done, pass, signature
  );

endinterface

// File: rtl/ccg_misr.sv
// rtl/ccg_misr.sv - multiple-input signature register compacting CUT responses
module ccg_misr
  import ccg_test_pkg::*;
#(
  parameter int SIG_W = CCG_SIG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SIG_W-1:0] seed,
  input  logic             en,
  input  logic [SIG_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  localparam logic [SIG_W-1:0] POLY = SIG_W'(CCG_POLY);

  // reset/load return to the seed; otherwise shift, fold in the feedback polynomial and the response
  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= seed;
    end else if (load) begin
      sig <= seed;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ din;
    end
  end

endmodule

// File: rtl/ccg_response_analyzer.sv
// rtl/ccg_response_analyzer.sv - exhaustive stimulus sequencer with MISR-based pass/fail check
module ccg_response_analyzer
  import ccg_test_pkg::*;
#(
  parameter int               N_IN   = 3,
  parameter int               N_OUT  = 10,
  parameter int               SIG_W  = CCG_SIG_W,
  parameter int               SETTLE = 1,
  parameter logic [SIG_W-1:0] SEED   = '0
) (
  input logic                    clk,
  input logic                    rst,
  ccg_response_analyzer_if.slave bus
);

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0]  LAST_PAT    = '1;
  localparam logic [SIG_W-1:0] POLY        = SIG_W'(CCG_POLY);

  ccg_state_t       state;
  logic [N_IN-1:0]  x_q;
  logic [3:0]       settle_cnt;
  logic [SIG_W-1:0] golden_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic [N_OUT-1:0] f_w;
  logic [SIG_W-1:0] din_ext;
  logic [SIG_W-1:0] sig;
  logic [SIG_W-1:0] sig_next;
  logic             accept;
  logic             capture;

  assign f_w     = bus.f;
  assign din_ext = SIG_W'(f_w);
  assign accept  = ((state == ST_IDLE) || (state == ST_DONE)) && bus.start;
  assign capture = (state == ST_CAPTURE);

  // signature the MISR will hold after this edge's capture, so pass can be registered together with done
  always_comb begin
    sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ din_ext;
  end

  ccg_misr #(
    .SIG_W (SIG_W)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .seed (SEED),
    .en   (capture),
    .din  (din_ext),
    .sig  (sig)
  );

  // run sequencer: the pattern counter doubles as the stimulus vector, which stops at the last pattern
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      x_q        <= '0;
      settle_cnt <= '0;
      golden_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state      <= ST_APPLY;
            x_q        <= '0;
            settle_cnt <= '0;
            golden_q   <= bus.golden;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
          end
        end
        ST_APPLY: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= ST_CAPTURE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        ST_CAPTURE: begin
          if (x_q == LAST_PAT) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (sig_next == golden_q);
          end else begin
            x_q   <= x_q + N_IN'(1);
            state <= ST_APPLY;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.x         = x_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.signature = sig;

endmodule
